// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style control unit: sequences fetch, decode, memory, ALU,
// branch and jump steps and drives the datapath enables and selects.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_rdy,
    input  logic       zero,
    input  logic       sign,
    input  logic       overflow,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       ir_we,
    output logic       mem_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [3:0] alu_op,
    output logic       exc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_ovf_q;
    logic   w_pc_we;
    logic   w_ir_we;
    logic   w_mem_we;
    logic   w_reg_we;
    logic   w_exc;
    logic   w_funct_ok;

    assign w_funct_ok = (funct[5:3] == 3'b100);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ovf_q <= 1'b0;
        end else begin
            r_state <= w_next;
            // Only signed ADD/SUB trap; the flag lives for the write-back cycle alone.
            r_ovf_q <= ((r_state == S_EXEC) || (r_state == S_IEXEC)) && overflow &&
                       ((alu_op == 4'd0) || (alu_op == 4'd2));
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pc_we    = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        w_ir_we    = 1'b0;
        w_mem_we   = 1'b0;
        w_reg_we   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        alu_op     = 4'd1;
        w_exc      = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                w_ir_we   = mem_rdy;
                w_pc_we   = mem_rdy;
                w_next    = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    6'h00: begin
                        if (w_funct_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            w_exc = 1'b1;
                        end
                    end
                    6'h23, 6'h2B:               w_next = S_MEMADR;
                    6'h04, 6'h05, 6'h07:        w_next = S_BRANCH;
                    6'h02:                      w_next = S_JUMP;
                    6'h08, 6'h09, 6'h0C, 6'h0D,
                    6'h0E:                      w_next = S_IEXEC;
                    default:                    w_exc  = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_we   = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                w_mem_we = 1'b1;
                w_next   = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                // Decode admitted only funct 0x20..0x27, so funct-0x20 is its low 3 bits.
                alu_op    = {1'b0, funct[2:0]};
                w_next    = S_RWB;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_IWB;
                case (op)
                    6'h08:   alu_op = 4'd0;
                    6'h0C: begin alu_op = 4'd4; ext_zero = 1'b1; end
                    6'h0D: begin alu_op = 4'd5; ext_zero = 1'b1; end
                    6'h0E: begin alu_op = 4'd6; ext_zero = 1'b1; end
                    default: alu_op = 4'd1;
                endcase
            end
            S_RWB, S_IWB: begin
                reg_dst  = (r_state == S_RWB);
                w_reg_we = ~r_ovf_q;
                w_exc    = r_ovf_q;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                case (op)
                    6'h04:   begin alu_op = 4'd2; w_pc_we = zero;         end
                    6'h05:   begin alu_op = 4'd2; w_pc_we = ~zero;        end
                    default: begin alu_op = 4'd8; w_pc_we = sign & ~zero; end
                endcase
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                w_pc_we = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts.
    assign pc_we  = w_pc_we  & rst_n;
    assign ir_we  = w_ir_we  & rst_n;
    assign mem_we = w_mem_we & rst_n;
    assign reg_we = w_reg_we & rst_n;
    assign exc    = w_exc    & rst_n;
    assign state  = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its
// states and compares outputs with hand-computed values.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       mem_rdy = 1'b0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       overflow = 1'b0;
    logic       pc_we, iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, ext_zero, exc;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op, state;

    int n_checks = 0;
    int n_pass   = 0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_rdy(mem_rdy),
        .zero(zero), .sign(sign), .overflow(overflow), .pc_we(pc_we),
        .pc_src(pc_src), .iord(iord), .ir_we(ir_we), .mem_we(mem_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .alu_op(alu_op), .exc(exc), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with mem_rdy high, issue op/funct and advance into DECODE.
    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        op = o; funct = f; mem_rdy = 1'b1;
        check("fetch_state", int'(state), 0);
        check("fetch_ir_we", int'(ir_we), 1);
        step();
        check("decode_state", int'(state), 1);
    endtask

    initial begin
        // Reset: strobes held low even though FETCH would follow mem_rdy
        mem_rdy = 1'b1;
        #2;
        check("rst_state", int'(state), 0);
        check("rst_ir_we", int'(ir_we), 0);
        check("rst_pc_we", int'(pc_we), 0);
        step();
        check("rst_hold_state", int'(state), 0);
        check("rst_hold_pc_we", int'(pc_we), 0);
        rst_n = 1'b1;
        #1;
        check("fetch_pc_we", int'(pc_we), 1);
        check("fetch_srcb", int'(alu_src_b), 1);

        // ADD with overflow traps
        issue(6'h00, 6'h20);
        check("decode_srcb", int'(alu_src_b), 3);
        overflow = 1'b1;
        step();
        check("exec_state", int'(state), 6);
        check("exec_alu_op", int'(alu_op), 0);
        check("exec_srca", int'(alu_src_a), 1);
        step();
        check("rwb_add_state", int'(state), 7);
        check("rwb_add_reg_we", int'(reg_we), 0);
        check("rwb_add_exc", int'(exc), 1);
        check("rwb_add_reg_dst", int'(reg_dst), 1);
        step();
        check("after_rwb_state", int'(state), 0);
        check("after_rwb_exc", int'(exc), 0);

        // ADDU with overflow does not trap
        issue(6'h00, 6'h21);
        step();
        check("exec_addu_alu_op", int'(alu_op), 1);
        step();
        check("rwb_addu_reg_we", int'(reg_we), 1);
        check("rwb_addu_exc", int'(exc), 0);
        step();

        // SUB (funct 0x22) with overflow traps
        issue(6'h00, 6'h22);
        step();
        check("exec_sub_alu_op", int'(alu_op), 2);
        step();
        check("rwb_sub_exc", int'(exc), 1);
        overflow = 1'b0;
        step();

        // LW with three wait cycles: 0,1,2,3,3,3,3,4,0
        issue(6'h23, 6'h00);
        step();
        check("memadr_state", int'(state), 2);
        check("memadr_srcb", int'(alu_src_b), 2);
        mem_rdy = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("memrd_wait_state", int'(state), 3);
            check("memrd_wait_iord", int'(iord), 1);
            check("memrd_wait_reg_we", int'(reg_we), 0);
            step();
        end
        check("memrd_last_state", int'(state), 3);
        mem_rdy = 1'b1;
        step();
        check("memwb_state", int'(state), 4);
        check("memwb_reg_we", int'(reg_we), 1);
        check("memwb_mem_to_reg", int'(mem_to_reg), 1);
        check("memwb_reg_dst", int'(reg_dst), 0);
        step();
        check("lw_done_state", int'(state), 0);

        // BGTZ
        issue(6'h07, 6'h00);
        sign = 1'b1; zero = 1'b0;
        step();
        check("bgtz_state", int'(state), 8);
        check("bgtz_pc_we", int'(pc_we), 1);
        check("bgtz_alu_op", int'(alu_op), 8);
        zero = 1'b1;
        #1;
        check("bgtz_zero_pc_we", int'(pc_we), 0);
        step();

        // BNE taken-not, BEQ taken
        issue(6'h05, 6'h00);
        step();
        check("bne_pc_we", int'(pc_we), 0);
        check("bne_alu_op", int'(alu_op), 2);
        step();
        issue(6'h04, 6'h00);
        step();
        check("beq_pc_we", int'(pc_we), 1);
        check("beq_pc_src", int'(pc_src), 1);
        step();
        zero = 1'b0; sign = 1'b0;

        // Jump
        issue(6'h02, 6'h00);
        step();
        check("jump_state", int'(state), 9);
        check("jump_pc_we", int'(pc_we), 1);
        check("jump_pc_src", int'(pc_src), 2);
        step();

        // ORI ignores overflow; ADDI traps on it
        issue(6'h0D, 6'h00);
        overflow = 1'b1;
        step();
        check("ori_state", int'(state), 10);
        check("ori_alu_op", int'(alu_op), 5);
        check("ori_ext_zero", int'(ext_zero), 1);
        step();
        check("ori_iwb_state", int'(state), 11);
        check("ori_iwb_reg_we", int'(reg_we), 1);
        check("ori_iwb_exc", int'(exc), 0);
        step();
        issue(6'h08, 6'h00);
        step();
        check("addi_alu_op", int'(alu_op), 0);
        check("addi_ext_zero", int'(ext_zero), 0);
        step();
        check("addi_iwb_reg_we", int'(reg_we), 0);
        check("addi_iwb_exc", int'(exc), 1);
        overflow = 1'b0;
        step();

        // Illegal opcode and illegal funct
        issue(6'h3F, 6'h00);
        check("illegal_op_exc", int'(exc), 1);
        check("illegal_op_pc_we", int'(pc_we), 0);
        check("illegal_op_ir_we", int'(ir_we), 0);
        check("illegal_op_reg_we", int'(reg_we), 0);
        check("illegal_op_mem_we", int'(mem_we), 0);
        step();
        check("illegal_op_next", int'(state), 0);
        check("illegal_op_exc_gone", int'(exc), 0);
        issue(6'h00, 6'h2A);
        check("illegal_funct_exc", int'(exc), 1);
        step();
        check("illegal_funct_next", int'(state), 0);

        // SW held in MEMWR, then reset mid-hold
        issue(6'h2B, 6'h00);
        step();
        mem_rdy = 1'b0;
        step();
        check("memwr_state", int'(state), 5);
        check("memwr_mem_we", int'(mem_we), 1);
        step();
        check("memwr_hold_mem_we", int'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("memwr_rst_mem_we", int'(mem_we), 0);
        check("memwr_rst_state", int'(state), 0);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_state", int'(state), 0);
        check("post_rst_mem_we", int'(mem_we), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
